// File: rtl/pid_link_pkg.sv
// Shared constants, command codes, frame geometry and FSM state encoding for the PID host link.
// Optional build macro: PID_FRAME_CHECKSUM_EN (adds an XOR checksum byte ahead of END_BYTE).
// No logic here; imported by pid_frame_pack and pid_frame_tx.
package pid_link_pkg;

  localparam logic [7:0] START_BYTE = 8'hAA;
  localparam logic [7:0] END_BYTE   = 8'hBB;

  // Payload width; the upper frame byte carries PAYLOAD_W-32 bits, zero-padded.
  localparam int PAYLOAD_W = 36;

  localparam logic [7:0] CMD_RESET = 8'd0;
  localparam logic [7:0] CMD_KP    = 8'd1;
  localparam logic [7:0] CMD_KD    = 8'd2;
  localparam logic [7:0] CMD_KI    = 8'd3;

`ifdef PID_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  // Byte index width: wide enough for the 9-byte variant, never wraps.
  localparam int                IDX_W    = 4;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    WAIT_DONE,
    FINISH
  } state_t;

`ifdef PID_FRAME_CHECKSUM_EN
  // XOR of the command byte and the five payload bytes as they appear on the wire.
  function automatic logic [7:0] frame_checksum(input logic [7:0]           cmd,
                                                input logic [PAYLOAD_W-1:0] payload);
    logic [39:0] p;
    p = 40'(payload);
    return cmd ^ p[39:32] ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
  endfunction
`endif

endpackage

// File: rtl/pid_frame_pack.sv
// Purpose: combinational packing of cmd + payload into the wire frame (byte 0 in bits [7:0]).
// Latency: zero cycles, pure combinational.
// Backpressure: none; the caller decides when to capture the packed frame.
// Optional build macro: PID_FRAME_CHECKSUM_EN inserts the checksum byte before END_BYTE.
module pid_frame_pack
  import pid_link_pkg::*;
(
  input  logic [7:0]             cmd_i,
  input  logic [PAYLOAD_W-1:0]   payload_i,
  output logic [8*FRAME_LEN-1:0] frame_o
);

  // Lay out the frame bytes in transmit order, lowest byte first.
  always_comb begin
    frame_o          = '0;
    frame_o[0*8 +: 8] = START_BYTE;
    frame_o[1*8 +: 8] = cmd_i;
    // Upper payload bits are zero-extended into a full byte.
    frame_o[2*8 +: 8] = 8'(payload_i[PAYLOAD_W-1:32]);
    frame_o[3*8 +: 8] = payload_i[31:24];
    frame_o[4*8 +: 8] = payload_i[23:16];
    frame_o[5*8 +: 8] = payload_i[15:8];
    frame_o[6*8 +: 8] = payload_i[7:0];
`ifdef PID_FRAME_CHECKSUM_EN
    frame_o[7*8 +: 8] = frame_checksum(cmd_i, payload_i);
    frame_o[8*8 +: 8] = END_BYTE;
`else
    frame_o[7*8 +: 8] = END_BYTE;
`endif
  end

endmodule

// File: rtl/pid_frame_tx.sv
// Purpose: serialize one PID host-link frame into a byte-wide UART transmitter.
// Latency: first o_TX_DV 2 cycles after i_Frame_DV; each next byte 2 cycles after i_TX_Done.
// Backpressure: holds in ARM while i_TX_Active; requests while busy are dropped with o_Frame_Drop.
// Optional build macro: PID_FRAME_CHECKSUM_EN (9-byte frame with checksum).
module pid_frame_tx
  import pid_link_pkg::*;
(
  input  logic                 i_Clk,
  input  logic                 reset,
  input  logic                 i_Frame_DV,
  input  logic [7:0]           i_Cmd,
  input  logic [PAYLOAD_W-1:0] i_Payload,
  output logic                 o_Busy,
  output logic                 o_Frame_Done,
  output logic                 o_Frame_Drop,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done
);

  state_t                 state_q, state_d;
  logic [8*FRAME_LEN-1:0] buf_q, buf_d;
  logic [8*FRAME_LEN-1:0] packed_frame;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   tx_dv_q, tx_dv_d;
  logic [7:0]             tx_byte_q, tx_byte_d;

  pid_frame_pack u_pack (
    .cmd_i     (i_Cmd),
    .payload_i (i_Payload),
    .frame_o   (packed_frame)
  );

  // State, shift buffer, byte index and registered UART drive; reset returns all to idle values.
  always_ff @(posedge i_Clk) begin
    if (reset) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      idx_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Next-state logic: the buffer shifts down one byte per completed transfer,
  // so the byte to send is always in buf_q[7:0].
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    idx_d     = idx_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    case (state_q)
      IDLE: begin
        if (i_Frame_DV) begin
          buf_d   = packed_frame;
          idx_d   = '0;
          state_d = ARM;
        end
      end
      ARM: begin
        if (!i_TX_Active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = buf_q[7:0];
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // o_TX_Byte is held in tx_byte_q until the transfer finishes.
        if (i_TX_Done) begin
          if (idx_q == LAST_IDX) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            buf_d   = {8'h00, buf_q[8*FRAME_LEN-1:8]};
            state_d = ARM;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the state; drop is suppressed while reset is asserted.
  always_comb begin
    o_Busy       = (state_q != IDLE);
    o_Frame_Done = (state_q == FINISH);
    o_Frame_Drop = i_Frame_DV && (state_q != IDLE) && !reset;
    o_TX_DV      = tx_dv_q;
    o_TX_Byte    = tx_byte_q;
  end

endmodule

// File: tb/tb_pid_frame_tx.sv
// Bench for pid_frame_tx: table of frames with hand-computed wire bytes, a behavioural
// UART transmitter (10 bit times of 4 clocks per byte), and directed corner sequences.
// Builds for both the 8-byte and the PID_FRAME_CHECKSUM_EN 9-byte frame.
module tb_pid_frame_tx;

  localparam int CPB = 4;
`ifdef PID_FRAME_CHECKSUM_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_Frame_DV = 1'b0;
  logic [7:0]  i_Cmd = 8'h00;
  logic [35:0] i_Payload = '0;
  logic        o_Busy, o_Frame_Done, o_Frame_Drop, o_TX_DV;
  logic [7:0]  o_TX_Byte;
  logic        i_TX_Active, i_TX_Done;

  pid_frame_tx dut (
    .i_Clk        (clk),
    .reset        (reset),
    .i_Frame_DV   (i_Frame_DV),
    .i_Cmd        (i_Cmd),
    .i_Payload    (i_Payload),
    .o_Busy       (o_Busy),
    .o_Frame_Done (o_Frame_Done),
    .o_Frame_Drop (o_Frame_Drop),
    .o_TX_DV      (o_TX_DV),
    .o_TX_Byte    (o_TX_Byte),
    .i_TX_Active  (i_TX_Active),
    .i_TX_Done    (i_TX_Done)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural UART transmitter; not reset by the DUT reset, like the real line driver.
  logic       uart_busy = 1'b0;
  logic       tx_done = 1'b0;
  logic       hold_active = 1'b0;
  logic       stab_en = 1'b1;
  logic [7:0] uart_byte = 8'h00;
  int         uart_cnt = 0;
  int         stab_err = 0;

  assign i_TX_Active = uart_busy | hold_active;
  assign i_TX_Done   = tx_done;

  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (!uart_busy) begin
      if (o_TX_DV) begin
        uart_busy <= 1'b1;
        uart_cnt  <= 0;
        uart_byte <= o_TX_Byte;
      end
    end else begin
      if (stab_en && (o_TX_Byte != uart_byte)) stab_err <= stab_err + 1;
      if (uart_cnt == 10*CPB-1) begin
        uart_busy <= 1'b0;
        tx_done   <= 1'b1;
      end else begin
        uart_cnt <= uart_cnt + 1;
      end
    end
  end

  // Event recorder, sampled mid low phase.
  logic [7:0] line_q[$];
  int         dv_cyc_q[$];
  int         txd_cyc_q[$];
  int         fdone_cnt = 0;
  int         drop_cnt = 0;

  always @(negedge clk) begin
    #2;
    if (o_TX_DV) begin
      line_q.push_back(o_TX_Byte);
      dv_cyc_q.push_back(cyc);
    end
    if (i_TX_Done)    txd_cyc_q.push_back(cyc);
    if (o_Frame_Done) fdone_cnt = fdone_cnt + 1;
    if (o_Frame_Drop) drop_cnt = drop_cnt + 1;
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [35:0] pay;
    logic [63:0] exp;   // 8-byte frame, first byte in the top bits
    logic [7:0]  ck;    // checksum byte for the 9-byte build
  } vec_t;

  vec_t vt [0:5];

  int n_chk = 0;
  int n_pass = 0;
  logic [35:0] kd_reg = '0;
  logic [35:0] ki_reg = '1;

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  // Called at a negedge; returns at the following negedge with the request withdrawn.
  task automatic send(input logic [7:0] cmd, input logic [35:0] pay, output int req);
    i_Frame_DV = 1'b1;
    i_Cmd      = cmd;
    i_Payload  = pay;
    req        = cyc;
    @(negedge clk);
    i_Frame_DV = 1'b0;
  endtask

  task automatic wait_fdone(output int fc, output bit ok);
    ok = 1'b0;
    fc = 0;
    for (int i = 0; i < 1500; i++) begin
      if (o_Frame_Done) begin
        ok = 1'b1;
        fc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_dvs(input int n, output bit ok);
    int c;
    c  = 0;
    ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (o_TX_DV) c++;
      if (c == n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic snap(output int sl, output int sd, output int st, output int fb, output int sb);
    sl = line_q.size();
    sd = dv_cyc_q.size();
    st = txd_cyc_q.size();
    fb = fdone_cnt;
    sb = stab_err;
  endtask

  // Checks one finished frame; called at the negedge after o_Frame_Done.
  task automatic check_frame(input int v, input int sl, input int sd, input int st,
                             input int fb, input int sb, input int fc, input int first_dv);
    logic [71:0] got, exp;
    logic [7:0]  b [0:8];
    logic [35:0] pv;
    int          bad;
    chk("frame_len", 72'(line_q.size() - sl), 72'(FL));
    chk("tx_done_count", 72'(txd_cyc_q.size() - st), 72'(FL));
    if ((line_q.size() - sl != FL) || (txd_cyc_q.size() - st != FL) ||
        (dv_cyc_q.size() - sd != FL)) return;
    got = '0;
    for (int k = 0; k < 9; k++) b[k] = 8'h00;
    for (int k = 0; k < FL; k++) begin
      b[k] = line_q[sl+k];
      got  = {got[63:0], b[k]};
    end
`ifdef PID_FRAME_CHECKSUM_EN
    exp = {vt[v].exp[63:8], vt[v].ck, 8'hBB};
`else
    exp = {8'h00, vt[v].exp};
`endif
    chk("frame_bytes", got, exp);
    chk("first_dv_cycle", 72'(dv_cyc_q[sd]), 72'(first_dv));
    bad = 0;
    for (int k = 1; k < FL; k++)
      if (dv_cyc_q[sd+k] - txd_cyc_q[st+k-1] != 2) bad++;
    chk("byte_gap_errors", 72'(bad), 72'(0));
    chk("frame_done_delay", 72'(fc - txd_cyc_q[st+FL-1]), 72'(1));
    chk("frame_done_count", 72'(fdone_cnt - fb), 72'(1));
    chk("byte_stability_errors", 72'(stab_err - sb), 72'(0));
    pv = {b[2][3:0], b[3], b[4], b[5], b[6]};
    chk("parser_payload", 72'(pv), 72'(vt[v].pay));
    if (b[1] == 8'd2) kd_reg = pv;
    if (b[1] == 8'd3) ki_reg = pv;
  endtask

  initial begin
    int  sl, sd, st, fb, sb, db, fc, req, rel;
    bit  ok;

    vt[0] = '{8'h01, 36'h1_2345_6789, 64'hAA01_0123_4567_89BB, 8'h88};
    vt[1] = '{8'h02, 36'hF_FFFF_FFFF, 64'hAA02_0FFF_FFFF_FFBB, 8'h0D};
    vt[2] = '{8'h03, 36'h0_0000_0000, 64'hAA03_0000_0000_00BB, 8'h03};
    vt[3] = '{8'h00, 36'hA_5A5A_5A5A, 64'hAA00_0A5A_5A5A_5ABB, 8'h0A};
    vt[4] = '{8'h03, 36'h0_0000_00FF, 64'hAA03_0000_0000_FFBB, 8'hFC};
    vt[5] = '{8'h01, 36'h8_0000_0001, 64'hAA01_0800_0000_01BB, 8'h08};

    // Reset with a simultaneous request: reset must win.
    i_Frame_DV = 1'b1;
    i_Cmd      = 8'h01;
    i_Payload  = 36'h1_2345_6789;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 72'({o_Busy, o_Frame_Done, o_Frame_Drop, o_TX_DV, o_TX_Byte}), 72'(0));
    reset      = 1'b0;
    i_Frame_DV = 1'b0;
    @(negedge clk);
    chk("reset_beats_request_busy", 72'(o_Busy), 72'(0));
    chk("reset_beats_request_dv", 72'(o_TX_DV), 72'(0));
    @(negedge clk);

    // Table frames, each requested the cycle after the previous o_Frame_Done.
    for (int v = 0; v < 6; v++) begin
      snap(sl, sd, st, fb, sb);
      send(vt[v].cmd, vt[v].pay, req);
      wait_fdone(fc, ok);
      if (!ok) begin
        timeout("table_frame_done");
      end else begin
        @(negedge clk);
        check_frame(v, sl, sd, st, fb, sb, fc, req + 2);
        chk("idle_after_frame", 72'(o_Busy), 72'(0));
        if (v == 2) begin
          chk("parser_kd_all_ones", 72'(kd_reg), 72'(36'hF_FFFF_FFFF));
          chk("parser_ki_zero", 72'(ki_reg), 72'(0));
        end
      end
    end

    // Request during byte 3: dropped, frame unchanged, nothing follows.
    repeat (3) @(negedge clk);
    snap(sl, sd, st, fb, sb);
    db = drop_cnt;
    send(vt[0].cmd, vt[0].pay, req);
    wait_dvs(3, ok);
    if (!ok) timeout("busy_req_third_byte");
    repeat (5) @(negedge clk);
    i_Frame_DV = 1'b1;
    i_Cmd      = 8'h02;
    i_Payload  = 36'h0_DEAD_BEEF;
    #1;
    chk("busy_drop_pulse", 72'(o_Frame_Drop), 72'(1));
    @(negedge clk);
    i_Frame_DV = 1'b0;
    #1;
    chk("busy_drop_single_cycle", 72'(o_Frame_Drop), 72'(0));
    wait_fdone(fc, ok);
    if (!ok) begin
      timeout("busy_req_frame_done");
    end else begin
      @(negedge clk);
      check_frame(0, sl, sd, st, fb, sb, fc, req + 2);
      chk("busy_drop_count", 72'(drop_cnt - db), 72'(1));
      repeat (100) @(negedge clk);
      chk("no_second_frame", 72'(dv_cyc_q.size() - sd), 72'(FL));
    end

    // Request in the FINISH cycle is dropped.
    snap(sl, sd, st, fb, sb);
    db = drop_cnt;
    send(vt[3].cmd, vt[3].pay, req);
    wait_fdone(fc, ok);
    if (!ok) begin
      timeout("finish_frame_done");
    end else begin
      i_Frame_DV = 1'b1;
      i_Cmd      = 8'h01;
      i_Payload  = 36'h0_0000_0077;
      #1;
      chk("finish_drop_pulse", 72'(o_Frame_Drop), 72'(1));
      @(negedge clk);
      i_Frame_DV = 1'b0;
      check_frame(3, sl, sd, st, fb, sb, fc, req + 2);
      repeat (60) @(negedge clk);
      chk("finish_drop_no_frame", 72'(dv_cyc_q.size() - sd), 72'(FL));
      chk("finish_drop_count", 72'(drop_cnt - db), 72'(1));
      chk("finish_drop_idle", 72'(o_Busy), 72'(0));
    end

    // Transmitter held active for 100 cycles at frame start.
    snap(sl, sd, st, fb, sb);
    hold_active = 1'b1;
    send(vt[4].cmd, vt[4].pay, req);
    repeat (100) @(negedge clk);
    chk("held_no_dv", 72'(dv_cyc_q.size() - sd), 72'(0));
    chk("held_busy", 72'(o_Busy), 72'(1));
    hold_active = 1'b0;
    rel = cyc;
    wait_fdone(fc, ok);
    if (!ok) begin
      timeout("held_frame_done");
    end else begin
      @(negedge clk);
      check_frame(4, sl, sd, st, fb, sb, fc, rel + 1);
    end

    // Reset after 4 bytes; the in-flight byte's done must be ignored.
    snap(sl, sd, st, fb, sb);
    send(vt[1].cmd, vt[1].pay, req);
    wait_dvs(4, ok);
    if (!ok) timeout("reset_fourth_byte");
    stab_en = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    chk("midframe_reset_outputs",
        72'({o_Busy, o_Frame_Done, o_Frame_Drop, o_TX_DV, o_TX_Byte}), 72'(0));
    reset = 1'b0;
    repeat (120) @(negedge clk);
    stab_en = 1'b1;
    chk("reset_no_more_dv", 72'(dv_cyc_q.size() - sd), 72'(4));
    chk("reset_no_frame_done", 72'(fdone_cnt - fb), 72'(0));
    chk("reset_idle", 72'(o_Busy), 72'(0));

    // Recovery frame after the reset.
    snap(sl, sd, st, fb, sb);
    send(vt[5].cmd, vt[5].pay, req);
    wait_fdone(fc, ok);
    if (!ok) begin
      timeout("recovery_frame_done");
    end else begin
      @(negedge clk);
      check_frame(5, sl, sd, st, fb, sb, fc, req + 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
